// File: rtl/jtag_master_pkg.sv
// ============================================================================
// Module   : as_pack
// Brief    : Shared types and constants for the JTAG master engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package as_pack;

  localparam int JTAG_MAX_LEN = 64;

  typedef enum logic [1:0] {
    OP_TAP_RESET = 2'b00,
    OP_IR_SCAN   = 2'b01,
    OP_DR_SCAN   = 2'b10,
    OP_IDLE_CLK  = 2'b11
  } jtag_op_t;

  typedef enum logic [2:0] {
    ST_PRST    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_NAV_IN  = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_NAV_OUT = 3'd4,
    ST_RUNIDLE = 3'd5,
    ST_DONE    = 3'd6
  } jtag_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_tck_gen.sv
// ============================================================================
// Module   : jtag_tck_gen
// Brief    : TCK divider; strobes mark the last clk cycle of each TCK phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic tck_o,
  output logic fall_stb,
  output logic rise_stb
);

  localparam logic [7:0] c_top = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       r_tck;
  logic       w_end;

  assign w_end    = run_i && (r_cnt == c_top);
  assign rise_stb = w_end && !r_tck;
  assign fall_stb = w_end && r_tck;
  assign tck_o    = r_tck;

  always_ff @(posedge clk_i) begin
    if (rst_i || !run_i) begin
      r_cnt <= 8'd0;
      r_tck <= 1'b0;
    end else if (r_cnt == c_top) begin
      r_cnt <= 8'd0;
      r_tck <= ~r_tck;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/jtag_master.sv
// ============================================================================
// Module   : jtag_master
// Brief    : Command-driven JTAG TAP master (reset, IR/DR scan, idle clocks).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_master
  import as_pack::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = JTAG_MAX_LEN
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [6:0]         cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               busy_o,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i
);

  localparam int IW = max_int($clog2(MAX_LEN + 1), 7);

  jtag_state_t       r_state, w_nstate;
  logic [IW-1:0]     r_idx, w_nidx, r_len, w_len_eff;
  logic [MAX_LEN-1:0] r_sh, r_cap, r_bit, r_rsp_data;
  logic              r_run, r_tms, r_tdi, r_ready, r_rsp_valid, r_resp, r_is_ir;
  logic              w_fall, w_rise, w_last, w_ntms;
  jtag_op_t          w_op;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .run_i    (r_run),
    .tck_o    (tck_o),
    .fall_stb (w_fall),
    .rise_stb (w_rise)
  );

  assign w_op        = jtag_op_t'(cmd_op_i);
  assign cmd_ready_o = r_ready;
  assign busy_o      = ~r_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign tms_o       = r_tms;
  assign tdi_o       = r_tdi;

  // Scans saturate to the register width; idle clocks keep the full count.
  always_comb begin
    w_len_eff = IW'(cmd_len_i);
    if ((w_op == OP_IR_SCAN || w_op == OP_DR_SCAN) && (IW'(cmd_len_i) > IW'(MAX_LEN)))
      w_len_eff = IW'(MAX_LEN);
  end

  always_comb begin
    w_last = 1'b0;
    case (r_state)
      ST_PRST:               w_last = (r_idx == IW'(5));
      ST_NAV_IN:             w_last = r_is_ir ? (r_idx == IW'(3)) : (r_idx == IW'(2));
      ST_SHIFT, ST_RUNIDLE:  w_last = (r_idx == r_len - IW'(1));
      ST_NAV_OUT:            w_last = (r_idx == IW'(1));
      default:               w_last = 1'b0;
    endcase

    w_nstate = r_state;
    w_nidx   = r_idx + IW'(1);
    if (w_last && r_state == ST_NAV_IN) begin
      w_nstate = ST_SHIFT;
      w_nidx   = '0;
    end else if (w_last && r_state == ST_SHIFT) begin
      w_nstate = ST_NAV_OUT;
      w_nidx   = '0;
    end

    w_ntms = 1'b0;
    case (w_nstate)
      ST_PRST:    w_ntms = (w_nidx != IW'(5));
      ST_NAV_IN:  w_ntms = (w_nidx == '0) || (r_is_ir && w_nidx == IW'(1));
      ST_SHIFT:   w_ntms = (w_nidx == r_len - IW'(1));
      ST_NAV_OUT: w_ntms = (w_nidx == '0);
      default:    w_ntms = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_PRST;
      r_idx       <= '0;
      r_len       <= '0;
      r_run       <= 1'b1;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_resp      <= 1'b0;
      r_is_ir     <= 1'b0;
      r_sh        <= '0;
      r_cap       <= '0;
      r_bit       <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            r_sh    <= cmd_data_i;
            r_cap   <= '0;
            r_bit   <= MAX_LEN'(1);
            r_len   <= w_len_eff;
            r_is_ir <= (w_op == OP_IR_SCAN);
            r_idx   <= '0;
            r_tdi   <= 1'b0;
            if (w_len_eff == '0) begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= '0;
            end else begin
              r_ready <= 1'b0;
              r_run   <= 1'b1;
              r_resp  <= 1'b1;
              case (w_op)
                OP_TAP_RESET: begin r_state <= ST_PRST;    r_tms <= 1'b1; end
                OP_IDLE_CLK:  begin r_state <= ST_RUNIDLE; r_tms <= 1'b0; end
                default:      begin r_state <= ST_NAV_IN;  r_tms <= 1'b1; end
              endcase
            end
          end
        end
        ST_DONE: begin
          if (w_fall) begin
            r_state     <= ST_IDLE;
            r_run       <= 1'b0;
            r_ready     <= 1'b1;
            r_rsp_valid <= r_resp;
            if (r_resp) r_rsp_data <= r_cap;
          end
        end
        ST_PRST, ST_NAV_IN, ST_SHIFT, ST_NAV_OUT, ST_RUNIDLE: begin
          if (w_rise) begin
            if (r_state == ST_SHIFT) r_cap <= r_cap | (r_bit & {MAX_LEN{tdo_i}});
            // The final step of a sequence finishes its high phase in DONE.
            if (w_last && r_state != ST_NAV_IN && r_state != ST_SHIFT) r_state <= ST_DONE;
          end
          if (w_fall) begin
            r_state <= w_nstate;
            r_idx   <= w_nidx;
            r_tms   <= w_ntms;
            if (r_state == ST_SHIFT) r_bit <= r_bit << 1;
            if (w_nstate == ST_SHIFT) begin
              r_tdi <= r_sh[0];
              r_sh  <= r_sh >> 1;
            end else begin
              r_tdi <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_PRST;
          r_idx   <= '0;
          r_run   <= 1'b1;
          r_tms   <= 1'b1;
          r_resp  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtag_master.sv
// ============================================================================
// Module   : tb_jtag_master
// Brief    : Directed, table-driven bench for jtag_master (CLK_DIV=2, MAX_LEN=64).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtag_master;

  logic        clk, rst, cmd_valid, cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
  logic [1:0]  cmd_op, tdo_mode;
  logic [6:0]  cmd_len;
  logic [63:0] cmd_data, rsp_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit tms_q[$];
  bit tdi_q[$];
  int acc_q[$];
  int rsp_q[$];
  logic tck_prev = 1'b0;

  jtag_master #(.CLK_DIV(2), .MAX_LEN(64)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_len_i   (cmd_len),
    .cmd_data_i  (cmd_data),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy),
    .tck_o       (tck),
    .tms_o       (tms),
    .tdi_o       (tdi),
    .tdo_i       (tdo)
  );

  // tdo modes: 0 = tied low, 1 = looped from tdi, 2 = tied high
  assign tdo = (tdo_mode == 2'd1) ? tdi : (tdo_mode == 2'd2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
    if (rsp_valid) rsp_q.push_back(cyc);
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    tck_prev <= tck;
    if (tck && !tck_prev) begin
      tms_q.push_back(tms);
      tdi_q.push_back(tdi);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  len;
    logic [63:0] data;
    logic [1:0]  mode;
    int          tcks;
    logic [63:0] rsp;
    logic [15:0] tms16;
    logic [15:0] tdi16;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] pack16(input bit q[$]);
    logic [15:0] v = '0;
    for (int k = 0; k < 16; k++) if (k < q.size()) v[k] = q[k];
    return v;
  endfunction

  task automatic clear_q();
    tms_q.delete(); tdi_q.delete(); acc_q.delete(); rsp_q.delete();
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_tck"},       64'(tck),       64'd0);
    chk({p, "_tms"},       64'(tms),       64'd1);
    chk({p, "_tdi"},       64'(tdi),       64'd0);
    chk({p, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({p, "_rsp_data"},  rsp_data,       64'd0);
    chk({p, "_ready"},     64'(cmd_ready), 64'd0);
    chk({p, "_busy"},      64'(busy),      64'd1);
  endtask

  // Called at posedge+1 with queues cleared, right as rst is released.
  task automatic prst_check(input string p);
    rst = 1'b0;
    repeat (23) @(posedge clk);
    #1;
    chk({p, "_ready_c24"}, 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    chk({p, "_ready_c25"}, 64'(cmd_ready), 64'd1);
    chk({p, "_tcks"},      64'(tms_q.size()), 64'd6);
    chk({p, "_tms_seq"},   64'(pack16(tms_q)), 64'h001F);
    chk({p, "_no_rsp"},    64'(rsp_q.size()), 64'd0);
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 200 && acc_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 2000 && rsp_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    @(posedge clk);
    #1;
    clear_q();
    tdo_mode = v.mode; cmd_op = v.op; cmd_len = v.len; cmd_data = v.data;
    cmd_valid = 1'b1;
    wait_acc(1);
    cmd_valid = 1'b0;
    cmd_data = {$urandom, $urandom};
    cmd_op   = 2'($urandom);
    cmd_len  = 7'($urandom);
    wait_rsp(1);
    repeat (3) @(posedge clk);
    #1;
    chk({p, "_accepted"}, 64'(acc_q.size()), 64'd1);
    chk({p, "_rsp_cnt"},  64'(rsp_q.size()), 64'd1);
    if (acc_q.size() == 1 && rsp_q.size() == 1)
      chk({p, "_latency"}, 64'(rsp_q[0] - acc_q[0]), 64'(1 + 4 * v.tcks));
    chk({p, "_tcks"},     64'(tms_q.size()), 64'(v.tcks));
    chk({p, "_rsp_data"}, rsp_data, v.rsp);
    chk({p, "_tms_seq"},  64'(pack16(tms_q)), 64'(v.tms16));
    chk({p, "_tdi_seq"},  64'(pack16(tdi_q)), 64'(v.tdi16));
  endtask

  initial begin
    vecs[0] = '{2'd2, 7'd8,   64'hA5,                  2'd1, 13,  64'hA5,                  16'h0C01, 16'h0528};
    vecs[1] = '{2'd2, 7'd0,   64'hFF,                  2'd1, 0,   64'h0,                   16'h0000, 16'h0000};
    vecs[2] = '{2'd1, 7'd5,   64'h1F,                  2'd0, 11,  64'h0,                   16'h0303, 16'h01F0};
    vecs[3] = '{2'd2, 7'd100, 64'hDEADBEEF_01234567,   2'd1, 69,  64'hDEADBEEF_01234567,   16'h0001, 16'h2B38};
    vecs[4] = '{2'd3, 7'd3,   64'hFFFF,                2'd1, 3,   64'h0,                   16'h0000, 16'h0000};
    vecs[5] = '{2'd0, 7'd1,   64'hFFFF,                2'd2, 6,   64'h0,                   16'h001F, 16'h0000};
    vecs[6] = '{2'd2, 7'd4,   64'hFF,                  2'd2, 9,   64'hF,                   16'h00C1, 16'h0078};
    vecs[7] = '{2'd3, 7'd100, 64'hFFFF,                2'd2, 100, 64'h0,                   16'h0000, 16'h0000};
    vecs[8] = '{2'd1, 7'd3,   64'hFD,                  2'd1, 9,   64'h5,                   16'h00C3, 16'h0050};
    vecs[9] = '{2'd0, 7'd0,   64'h0,                   2'd2, 0,   64'h0,                   16'h0000, 16'h0000};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 7'd0; cmd_data = '0; tdo_mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    clear_q();
    prst_check("prst");

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Back-to-back idle clocks with cmd_valid held high.
    @(posedge clk);
    #1;
    clear_q();
    tdo_mode = 2'd1; cmd_op = 2'd3; cmd_len = 7'd3; cmd_data = '1;
    cmd_valid = 1'b1;
    wait_acc(2);
    cmd_valid = 1'b0;
    wait_rsp(2);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_acc_cnt", 64'(acc_q.size()), 64'd2);
    chk("b2b_rsp_cnt", 64'(rsp_q.size()), 64'd2);
    if (acc_q.size() == 2 && rsp_q.size() == 2) begin
      chk("b2b_second_accept", 64'(acc_q[1]), 64'(rsp_q[0]));
      chk("b2b_latency1",      64'(rsp_q[0] - acc_q[0]), 64'd13);
      chk("b2b_latency2",      64'(rsp_q[1] - acc_q[1]), 64'd13);
    end
    chk("b2b_tcks",    64'(tms_q.size()), 64'd6);
    chk("b2b_tms",     64'(pack16(tms_q)), 64'd0);
    chk("b2b_tdi",     64'(pack16(tdi_q)), 64'd0);

    // Reset during shift bit 3 of a 32-bit DR scan.
    @(posedge clk);
    #1;
    clear_q();
    tdo_mode = 2'd1; cmd_op = 2'd2; cmd_len = 7'd32; cmd_data = 64'hFFFF_FFFF;
    cmd_valid = 1'b1;
    wait_acc(1);
    cmd_valid = 1'b0;
    for (int i = 0; i < 200 && tms_q.size() < 7; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_reached_bit3", 64'(tms_q.size()), 64'd7);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("mid");
    chk("mid_no_rsp", 64'(rsp_q.size()), 64'd0);
    clear_q();
    prst_check("rerun");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
